pc_ras_unit: RTL
================

PC_RAS_UNIT -- requirements
Module: pc_ras_unit

Interface
REQ-001 Parameter XLEN, default 32, width of every address in bits.
REQ-002 Parameter RESET_VECTOR, default 32'h0, value loaded into current_pc on reset.
REQ-003 Parameter INC, default 4, sequential increment in bytes.
REQ-004 Parameter RAS_DEPTH, default 4, return-address-stack entries; legal range 2..16.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 reset  in  1  synchronous, active-high; sampled only at a rising clk edge.
REQ-007 stall  in  1  hold current_pc and RAS this cycle.
REQ-008 redirect_valid  in  1  branch or exception redirect request.
REQ-009 redirect_target  in  XLEN  redirect destination.
REQ-010 call  in  1  current instruction is a call; push return address.
REQ-011 call_target  in  XLEN  call destination.
REQ-012 ret  in  1  current instruction is a return; pop and jump.
REQ-013 current_pc  out  XLEN  registered program counter.
REQ-014 pc_seq  out  XLEN  combinational current_pc+INC, modulo 2^XLEN.
REQ-015 ras_top  out  XLEN  combinational top entry; 0 when empty.
REQ-016 ras_count  out  clog2(RAS_DEPTH+1)  valid entries.
REQ-017 ras_full / ras_empty  out  1 each  combinational ras_count==RAS_DEPTH / ras_count==0.
REQ-018 ras_underflow  out  1  registered one-cycle pulse, set in the cycle after an empty pop.

Function
REQ-019 Next-state priority, evaluated per edge: reset > redirect_valid > stall > call/ret > sequential.
REQ-020 The redirect shall load redirect_target, leave the RAS unchanged, and override stall, call and ret.
REQ-021 Stall without redirect shall hold current_pc, RAS contents and ras_count, and shall ignore call/ret.
REQ-022 Sequential: current_pc <= pc_seq; the increment wraps 2^XLEN-INC -> 0.
REQ-023 Call only: current_pc <= call_target; pc_seq pushed; ras_count +1.
REQ-024 Push when full: overwrite the oldest entry (circular); ras_count saturates at RAS_DEPTH.
REQ-025 Ret only, non-empty: current_pc <= ras_top; pop; ras_count -1.
REQ-026 Ret only, empty: current_pc <= pc_seq; ras_count stays 0; ras_underflow = 1 next cycle.
REQ-027 Call+ret, non-empty: current_pc <= ras_top; top entry replaced by pc_seq; ras_count unchanged.
REQ-028 Call+ret, empty: behave exactly as call only; no underflow.
REQ-029 ras_underflow = 0 in every cycle not covered by REQ-026.
REQ-030 Single-cycle latency: inputs sampled at edge N are visible on current_pc/ras_* after edge N.
REQ-031 No combinational path from any input to current_pc, ras_count or ras_underflow.

Reset
REQ-032 On reset: current_pc = RESET_VECTOR, ras_count = 0, ras_underflow = 0; ras_empty = 1, ras_top = 0.
REQ-033 Reset overrides all inputs, including mid-stall and mid-redirect; stack entry contents are don't-care after reset.
REQ-034 Outputs are undefined before the first reset edge; no initial-block values are required.

Verification
REQ-035 reset 1 cycle, then 3 idle cycles -> current_pc 0, 4, 8, 12; ras_empty = 1.
REQ-036 At pc 0x10, call to 0x100; 2 idle cycles; ret -> pc 0x100, 0x104, 0x108, then 0x14; ras_count 1 -> 0.
REQ-037 RAS_DEPTH = 4: 5 calls from pcs 0x0, 0x100, 0x200, 0x300, 0x400, then 5 rets -> pops 0x404, 0x304, 0x204, 0x104; 5th ret sequential; ras_underflow pulses once.
REQ-038 stall + call + redirect_valid (target 0x80) at one edge -> pc 0x80; ras_count unchanged; next cycle stall only -> pc holds 0x80.
REQ-039 XLEN = 32, pc 0xFFFFFFFC, idle -> pc 0x00000000.
REQ-040 Reset asserted during a call with ras_count = 2 -> pc = RESET_VECTOR, ras_count 0, no push.

Source files
------------

// File: rtl/pc_ras_unit.sv
// Program counter with an integrated circular return-address stack.
// Next PC priority: reset > redirect > stall > call/ret > sequential.
module pc_ras_unit #(
   parameter int unsigned            XLEN         = 32,
   parameter logic [XLEN-1:0]        RESET_VECTOR = '0,
   parameter int unsigned            INC          = 4,
   parameter int unsigned            RAS_DEPTH    = 4,
   localparam int unsigned           CW           = $clog2(RAS_DEPTH + 1),
   localparam int unsigned           PW           = $clog2(RAS_DEPTH)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_target,
   input  logic            call,
   input  logic [XLEN-1:0] call_target,
   input  logic            ret,
   output logic [XLEN-1:0] current_pc,
   output logic [XLEN-1:0] pc_seq,
   output logic [XLEN-1:0] ras_top,
   output logic [CW-1:0]   ras_count,
   output logic            ras_full,
   output logic            ras_empty,
   output logic            ras_underflow
);

   logic [XLEN-1:0] pc_q, pc_d;
   logic [CW-1:0]   count_q, count_d;
   logic [PW-1:0]   top_ptr_q, top_ptr_d;
   logic            underflow_q, underflow_d;
   logic [XLEN-1:0] ras_q [RAS_DEPTH];
   logic [XLEN-1:0] ras_d [RAS_DEPTH];
   logic [PW-1:0]   ptr_inc, ptr_dec;

   // Combinational views of the registered state.
   always_comb begin
      pc_seq    = pc_q + XLEN'(INC);
      ras_empty = (count_q == '0);
      ras_full  = (count_q == CW'(RAS_DEPTH));
      ras_top   = ras_empty ? '0 : ras_q[top_ptr_q];
      ptr_inc   = (top_ptr_q == PW'(RAS_DEPTH - 1)) ? '0 : top_ptr_q + PW'(1);
      ptr_dec   = (top_ptr_q == '0) ? PW'(RAS_DEPTH - 1) : top_ptr_q - PW'(1);
   end

   assign current_pc    = pc_q;
   assign ras_count     = count_q;
   assign ras_underflow = underflow_q;

   // Next-state selection for PC and stack.
   always_comb begin
      pc_d        = pc_seq;
      count_d     = count_q;
      top_ptr_d   = top_ptr_q;
      underflow_d = 1'b0;
      ras_d       = ras_q;
      if (redirect_valid) begin
         pc_d = redirect_target;
      end else if (stall) begin
         pc_d = pc_q;
      end else if (call && ret && !ras_empty) begin
         // Swap: jump to the return address and replace it in place.
         pc_d             = ras_top;
         ras_d[top_ptr_q] = pc_seq;
      end else if (call) begin
         // Full stack wraps onto the oldest entry; count saturates.
         pc_d           = call_target;
         top_ptr_d      = ptr_inc;
         ras_d[ptr_inc] = pc_seq;
         if (!ras_full) begin
            count_d = count_q + CW'(1);
         end
      end else if (ret) begin
         if (ras_empty) begin
            underflow_d = 1'b1;
         end else begin
            pc_d      = ras_top;
            top_ptr_d = ptr_dec;
            count_d   = count_q - CW'(1);
         end
      end
   end

   // Control state with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q        <= RESET_VECTOR;
         count_q     <= '0;
         top_ptr_q   <= PW'(RAS_DEPTH - 1);
         underflow_q <= 1'b0;
      end else begin
         pc_q        <= pc_d;
         count_q     <= count_d;
         top_ptr_q   <= top_ptr_d;
         underflow_q <= underflow_d;
      end
   end

   // Stack storage; contents are don't-care after reset, so no push is blocked here
   // beyond the reset gate that keeps reset from pushing.
   always_ff @(posedge clk) begin
      if (!reset) begin
         ras_q <= ras_d;
      end
   end

endmodule
